grostl_sbox_sched_m: RTL
========================

# grostl_sbox_sched_m

Round scheduler for the masked 64-byte Grøstl SubBytes layer in the dp512 design. Sequences the P and Q permutations, which take turns on the single masked S-box array. Before each round it generates fresh 512-bit input and output masks with an internal LFSR. The surrounding datapath muxes its P or Q state into the S-box layer under `sel_q` and registers the S-box output on `sb_en`.

## Interface
- `NROUNDS`, 10: rounds per permutation.
- `RND_W`, 4: width of the round counter; must satisfy 2^RND_W > NROUNDS.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a P/Q permutation pair; sampled only in IDLE.
- `seed` in 64: LFSR seed, captured on an accepted `start`.
- `imask` out [0:63][7:0]: input masks to the S-box array.
- `omask` out [0:63][7:0]: output masks to the S-box array.
- `sel_q` out 1: 0 = P state on the S-box layer, 1 = Q state.
- `sb_en` out 1: datapath captures the S-box output this cycle.
- `round` out RND_W: current round index, 0..NROUNDS-1.
- `busy` out 1: high from the accepted `start` until DONE.
- `done` out 1: one-cycle pulse when both permutations are finished.

## Operation
- FSM states: IDLE, REFRESH, SUB_P, SUB_Q, DONE.
- IDLE:
  - On `start`: load the LFSR with `seed`; if `seed` == 0, load 64'h1 instead.
  - Clear `round` and the refresh counter, then go to REFRESH.
- REFRESH, 8 cycles, refresh counter k = 0..7:
  - Each cycle the LFSR steps once. Polynomial is x^64+x^63+x^61+x^60+1, Fibonacci form, shifting left, feedback into bit 0.
  - Post-step value L is written to `imask[8k..8k+7]` with byte 0 = L[63:56].
  - L rotated left by 8·(k+1) bits (mod 64) is written to `omask[8k..8k+7]` in the same byte order.
  - After k = 7, go to SUB_P.
- SUB_P, 1 cycle: `sel_q`=0, `sb_en`=1. Go to SUB_Q.
- SUB_Q, 1 cycle: `sel_q`=1, `sb_en`=1.
  - If `round` == NROUNDS-1, go to DONE.
  - Otherwise increment `round` and go to REFRESH.
- DONE, 1 cycle: `done`=1, `busy`=0. Go to IDLE.
- Masks stay constant through SUB_P and SUB_Q of a round. P and Q therefore share one mask pair per round.
- `start` is ignored outside IDLE. `seed` is ignored except on an accepted `start`.
- `busy` is high in REFRESH, SUB_P and SUB_Q.

## Timing
- Reset values:
  - FSM in IDLE, LFSR = 64'h1, `imask` = `omask` = 0.
  - `round` = 0, `sel_q` = 0, `sb_en` = 0, `busy` = 0, `done` = 0.
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- `start` sampled high in cycle 0 → REFRESH occupies cycles 1–8, SUB_P cycle 9, SUB_Q cycle 10.
- Each round takes 10 cycles. `done` is high in cycle 10·NROUNDS+1 (cycle 101 at the default).
- A new `start` is accepted in the cycle after `done`.
- Reset asserted mid-operation forces the reset state immediately. Partially written masks are cleared; there is no resume.
- `rst_n` deasserting in the same cycle as `start`: `start` is not accepted in that cycle.

## Configuration
- `GROSTL_MASKING_EN` defined: behaviour exactly as above.
- `GROSTL_MASKING_EN` undefined:
  - REFRESH is never entered and the LFSR is removed.
  - `imask` and `omask` are tied to 0 and `seed` is unused.
  - The sequence is IDLE → SUB_P → SUB_Q per round, 2 cycles per round.
  - `done` is high in cycle 2·NROUNDS+1 (cycle 21 at the default).

## Structure
- The shared package `grostl_pkg` holds:
  - the FSM state enum `sched_state_t`;
  - the state typedef `state_t` = [0:63][7:0];
  - the LFSR tap constant and the zero-seed replacement constant 64'h1.
- One sub-module, `grostl_mask_lfsr`:
  - holds the 64-bit LFSR with load and step inputs and a 64-bit value output;
  - is instantiated only under `GROSTL_MASKING_EN`.
- The scheduler owns the mask registers and the row-write logic.

## Test plan
- Reset with no stimulus → all outputs at reset values, `busy` = 0, and no `sb_en` over 200 cycles.
- `start` with `seed` = 64'h0123456789ABCDEF:
  - `sb_en` pulses in cycles 9, 10, 19, 20, …, 99, 100, with `sel_q` 0/1 alternating;
  - `done` is high only in cycle 101;
  - `imask`/`omask` match a reference-model LFSR at every SUB_P.
- `seed` = 0 → masks identical to those from a run with `seed` = 64'h1.
- `start` held high throughout a run → exactly one `done` per 102 cycles. The second run starts in the cycle after `done` and reseeds from `seed`.
- `rst_n` pulsed low during round 4 REFRESH (k = 3):
  - outputs return to reset values in the same cycle;
  - a later `start` runs the full 10 rounds from `round` = 0.
- `GROSTL_MASKING_EN` undefined:
  - `sb_en` pulses in cycles 1–20 with `sel_q` alternating;
  - `done` is high in cycle 21;
  - masks stay 0 throughout.

Source files
------------

// File: rtl/grostl_pkg.sv
// Shared types and constants for the masked Groestl SubBytes round scheduler.
package grostl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRefresh,
    StSubP,
    StSubQ,
    StDone
  } sched_state_t;

  typedef logic [0:63][7:0] state_t;

  // x^64 + x^63 + x^61 + x^60 + 1, tapped at stages 64, 63, 61, 60
  localparam logic [63:0] LfsrTaps     = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LfsrZeroSeed = 64'h1;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LfsrTaps)};
  endfunction

  // n may be 64, which must wrap to the identity
  function automatic logic [63:0] rotl64(input logic [63:0] x, input logic [6:0] n);
    logic [127:0] d;
    d = {x, x} << n;
    return d[127:64];
  endfunction

endpackage

// File: rtl/grostl_mask_lfsr.sv
// 64-bit Fibonacci LFSR used as the mask source; an all-zero seed is replaced by 64'h1.
module grostl_mask_lfsr
  import grostl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [63:0] seed_i,
  output logic [63:0] value_o
);

  logic [63:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? LfsrZeroSeed : seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrZeroSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/grostl_sbox_sched_m.sv
// Round scheduler for the masked Groestl SubBytes layer: alternates P and Q on one S-box array.
// Mask refresh and the LFSR exist only when GROSTL_MASKING_EN is defined.
module grostl_sbox_sched_m
  import grostl_pkg::*;
#(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned RND_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      seed,
  output state_t           imask,
  output state_t           omask,
  output logic             sel_q,
  output logic             sb_en,
  output logic [RND_W-1:0] round,
  output logic             busy,
  output logic             done
);

  sched_state_t     state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             sb_en_q, sb_en_d;
  logic             sel_q_q, sel_q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef GROSTL_MASKING_EN
  logic [2:0]  cnt_q, cnt_d;
  state_t      imask_q, imask_d, omask_q, omask_d;
  logic        lfsr_load, lfsr_step;
  logic [63:0] lfsr_val, lfsr_nxt, lfsr_rot;

  grostl_mask_lfsr u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (seed),
    .value_o (lfsr_val)
  );

  // Row k takes the post-step value; its omask row is that value rotated by 8*(k+1)
  assign lfsr_nxt = lfsr_next(lfsr_val);
  assign lfsr_rot = rotl64(lfsr_nxt, ({4'd0, cnt_q} + 7'd1) << 3);
  assign imask    = imask_q;
  assign omask    = omask_q;
`else
  logic unused_seed;
  assign unused_seed = ^seed;
  assign imask       = '0;
  assign omask       = '0;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
`ifdef GROSTL_MASKING_EN
    cnt_d     = cnt_q;
    imask_d   = imask_q;
    omask_d   = omask_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          round_d = '0;
`ifdef GROSTL_MASKING_EN
          cnt_d     = '0;
          lfsr_load = 1'b1;
          state_d   = StRefresh;
`else
          state_d   = StSubP;
`endif
        end
      end
      StRefresh: begin
`ifdef GROSTL_MASKING_EN
        lfsr_step = 1'b1;
        for (int j = 0; j < 8; j++) begin
          imask_d[{cnt_q, 3'(j)}] = lfsr_nxt[63-8*j -: 8];
          omask_d[{cnt_q, 3'(j)}] = lfsr_rot[63-8*j -: 8];
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StSubP;
`else
        state_d = StIdle;
`endif
      end
      StSubP: state_d = StSubQ;
      StSubQ: begin
        if (round_q == RND_W'(NROUNDS - 1)) begin
          state_d = StDone;
        end else begin
          round_d = round_q + 1'b1;
`ifdef GROSTL_MASKING_EN
          state_d = StRefresh;
`else
          state_d = StSubP;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q
    sb_en_d = (state_d == StSubP) || (state_d == StSubQ);
    sel_q_d = (state_d == StSubQ);
    busy_d  = (state_d == StRefresh) || (state_d == StSubP) || (state_d == StSubQ);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      round_q <= '0;
      sb_en_q <= 1'b0;
      sel_q_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GROSTL_MASKING_EN
      cnt_q   <= '0;
      imask_q <= '0;
      omask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sb_en_q <= sb_en_d;
      sel_q_q <= sel_q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GROSTL_MASKING_EN
      cnt_q   <= cnt_d;
      imask_q <= imask_d;
      omask_q <= omask_d;
`endif
    end
  end

  assign round = round_q;
  assign sb_en = sb_en_q;
  assign sel_q = sel_q_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
